// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner arbiter driving a shared 3-bit bus; define MUX_RR_ARBITER_LOCK_EN to add a lock input
module mux_rr_arbiter #(
  parameter int         MAX_HOLD = 4,
  parameter logic [2:0] IDLE_VAL = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] d,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic        lock,
`endif
  output logic [3:0]  gnt,
  output logic        busy,
  output logic [1:0]  owner,
  output logic [2:0]  y
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);
  state_t     r_state, w_state;
  logic [1:0] r_owner, w_owner, r_last, w_last, w_pick_idle, w_pick_busy;
  logic [3:0] r_hold, w_hold, r_gnt;
  logic       w_lock, w_others, w_timeout;
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] p;
    p = base;
    for (int i = 3; i >= 0; i--) if (r[base + 2'(i)]) p = base + 2'(i);
    return p;
  endfunction
`ifdef MUX_RR_ARBITER_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif
  assign w_pick_idle = rr_pick(req, r_last + 2'd1);
  assign w_pick_busy = rr_pick(req, r_owner + 2'd1);
  assign w_others    = |(req & ~(4'b1 << r_owner));
  assign w_timeout   = r_hold == HOLD_MAX && !w_lock;
  // next owner / state: release first, then timeout rotation, else keep counting the tenure
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last  = r_last;
    w_hold  = r_hold;
    if (r_state == IDLE) begin
      if (|req) begin
        w_state = BUSY;
        w_owner = w_pick_idle;
        w_hold  = '0;
      end
    end else if (!req[r_owner]) begin
      w_last  = r_owner;
      w_hold  = '0;
      w_state = |req ? BUSY : IDLE;
      w_owner = |req ? w_pick_busy : 2'd0;
    end else if (w_timeout) begin
      w_last  = r_owner;
      w_hold  = '0;
      w_owner = w_others ? w_pick_busy : r_owner;
    end else begin
      w_hold  = r_hold == HOLD_MAX ? r_hold : r_hold + 4'd1;
    end
  end
  // state and registered grant; reset drops any grant on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= 2'd3;
      r_hold  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_hold  <= w_hold;
      r_gnt   <= w_state == BUSY ? 4'b1 << w_owner : 4'b0;
    end
  end
  assign gnt   = r_gnt;
  assign busy  = r_state == BUSY;
  assign owner = r_owner;
  assign y     = r_state == BUSY ? d[3*r_owner +: 3] : IDLE_VAL;
endmodule
